instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder: the inverse of the decoder. Accepts decoded fields (opcode_t, funct7, funct3, rs1, rs2, rd, immediate) and emits 32-bit instruction words.
- Each word carries a running byte address, so a test harness or boot loader can fill instruction memory.
- Expands the LI pseudo-instruction into LUI+ADDI over two output beats.
- Valid/ready on both sides; one registered output stage.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first emitted word after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inValid  in  1  input fields valid.
- inReady  out  1  encoder can accept the input this cycle.
- opcode  in  opcode_t  instruction class, same enum the decoder emits.
- funct7  in  7  R-type funct7; for I-type shifts (funct3=1 or 5), placed in imm[11:5].
- funct3  in  3  funct3 field.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- rd  in  5  destination register.
- immediate  in  32  sign-extended immediate, same convention as the decoder output.
- loadImm  in  1  LI pseudo-op (rd, immediate); all other fields ignored.
- outValid  out  1  instructionCode and instructionAddr valid.
- outReady  in  1  downstream accepts.
- instructionCode  out  32  encoded instruction.
- instructionAddr  out  32  byte address of instructionCode.
- illegal  out  1  asserted with a beat whose opcode is not a legal opcode_t value.

Behaviour:
- Reset (async assert, synchronous release):
  - outValid=0, instructionCode=0, illegal=0.
  - instructionAddr=BASE_ADDR; state=IDLE.
  - inReady is 1 in the first cycle after release.
- Handshakes:
  - Input transfer when inValid&&inReady.
  - Output transfer when outValid&&outReady.
  - While outValid=1 and outReady=0, outputs hold stable.
- inReady = (state==IDLE) && (!outValid || outReady). Combinational from outReady; no combinational path from inValid.
- Latency: accepted input appears on outputs the next cycle. Full throughput (one word per cycle) under continuous outReady.
- Address: instructionAddr += 4 on each output transfer, modulo 2^32; wraps 32'hFFFF_FFFC -> 0.
- Field encoding:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I / LOAD / JALR: imm[11:0]|rs1|funct3|rd|op. Shifts replace imm[11:5] with funct7.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - LUI / AUIPC: imm[31:12]|rd|op.
  - Immediate bits beyond the field width, and imm[0] for B/J, are dropped with no error.
- Illegal opcode: emit 32'h0000_0013 (NOP) with illegal=1. Address still advances.
- LI expansion (loadImm=1). Let lo=immediate[11:0] and up=(immediate+32'h800)[31:12].
  - If immediate is in [-2048,2047]: single beat ADDI rd,x0,lo.
  - Else if lo==0: single beat LUI rd,up.
  - Else two beats: LUI rd,up, then ADDI rd,rd,lo.
- State machine:
  - IDLE: on accepting a two-beat LI, load LUI into the output register, latch rd and lo, go to LI_2.
  - LI_2: inReady=0. On LUI output transfer, load ADDI into the output register; return to IDLE.
- Async reset mid-LI discards the pending ADDI and returns to IDLE with the address at BASE_ADDR.
- rd=0 is encoded verbatim; no suppression.

Test Plan:
- Reset, outReady=1; ADD x3,x1,x2 (rTypeInstruction, f7=0, f3=0) -> next cycle instructionCode=32'h002081b3, instructionAddr=0, illegal=0.
- BEQ x1,x2,-20 then JAL x1,32 back-to-back -> 32'hFE2086E3 @0, then 32'h020000ef @4; inReady held 1.
- LI x5,0x12345678 -> LUI 32'h123452b7 @0, then ADDI 32'h67828293 @4; inReady=0 during LI_2.
- LI x5,0x12345800 -> 32'h123462b7 then 32'h80028293. LI x5,-5 -> single beat 32'hFFB00293. LI x5,0x12345000 -> single beat 32'h123452b7.
- outReady=0 for 3 cycles after SW x2,16(x1) -> 32'h0020a823 held stable, inReady=0; then outReady=1 -> transfer and address increments by 4 once.
- Illegal opcode -> 32'h00000013 with illegal=1. Assert rst_n low during LI_2 -> outValid=0 immediately, address=BASE_ADDR, no ADDI emitted after release.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// Opcode classes shared with the decoder, plus the encoder's field-in / word-out handshake bundle.
// The master side drives decoded fields and outReady; the slave side is the encoder.
package instruction_encoder_pkg;

    typedef enum logic [3:0] {
        rTypeInstruction  = 4'd0,
        iTypeInstruction  = 4'd1,
        loadInstruction   = 4'd2,
        sTypeInstruction  = 4'd3,
        bTypeInstruction  = 4'd4,
        jalInstruction    = 4'd5,
        jalrInstruction   = 4'd6,
        luiInstruction    = 4'd7,
        auipcInstruction  = 4'd8
    } opcode_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

interface instruction_encoder_if;
    import instruction_encoder_pkg::*;

    logic        inValid;
    logic        inReady;
    opcode_t     opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] immediate;
    logic        loadImm;
    logic        outValid;
    logic        outReady;
    logic [31:0] instructionCode;
    logic [31:0] instructionAddr;
    logic        illegal;

    modport master (
        output inValid, opcode, funct7, funct3, rs1, rs2, rd, immediate, loadImm, outReady,
        input  inReady, outValid, instructionCode, instructionAddr, illegal
    );

    modport slave (
        input  inValid, opcode, funct7, funct3, rs1, rs2, rd, immediate, loadImm, outReady,
        output inReady, outValid, instructionCode, instructionAddr, illegal
    );

endinterface

// File: rtl/instruction_encoder.sv
// RV32I field-to-word encoder with LI expansion; one registered output stage, next-cycle latency.
// Output holds while stalled; input is refused during the second LI beat or when the output is blocked.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_encoder_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        LI_2 = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        out_valid_q;
    logic [31:0] code_q;
    logic [31:0] addr_q;
    logic        illegal_q;
    logic [4:0]  li_rd_q;
    logic [11:0] li_lo_q;

    logic        nxt_valid;
    logic [31:0] nxt_code;
    logic        nxt_illegal;
    logic        capture_li;

    logic        in_fire;
    logic        out_fire;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic [11:0] imm_i;

    logic [11:0] li_lo;
    logic [19:0] li_up;
    logic        li_small;
    logic        li_two;
    logic [31:0] li_first;

    function automatic logic [31:0] addi_word(input logic [4:0] rd_f, input logic [4:0] rs1_f,
                                              input logic [11:0] imm_f);
        return {imm_f, rs1_f, 3'b000, rd_f, OP_IMM};
    endfunction

    assign out_fire    = out_valid_q && bus.outReady;
    assign bus.inReady = (state_q == IDLE) && (!out_valid_q || bus.outReady);
    assign in_fire     = bus.inValid && bus.inReady;

    assign bus.outValid        = out_valid_q;
    assign bus.instructionCode = code_q;
    assign bus.instructionAddr = addr_q;
    assign bus.illegal         = illegal_q;

    // Immediate shifts carry the funct7 pattern (e.g. SRAI) in the upper immediate bits.
    assign imm_i = (bus.funct3 == 3'd1 || bus.funct3 == 3'd5)
                 ? {bus.funct7, bus.immediate[4:0]} : bus.immediate[11:0];

    always_comb begin
        enc_word  = NOP_WORD;
        enc_legal = 1'b1;
        case (bus.opcode)
            rTypeInstruction: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
            iTypeInstruction: enc_word = {imm_i, bus.rs1, bus.funct3, bus.rd, OP_IMM};
            loadInstruction:  enc_word = {bus.immediate[11:0], bus.rs1, bus.funct3, bus.rd, OP_LOAD};
            jalrInstruction:  enc_word = {bus.immediate[11:0], bus.rs1, bus.funct3, bus.rd, OP_JALR};
            sTypeInstruction: enc_word = {bus.immediate[11:5], bus.rs2, bus.rs1, bus.funct3,
                                          bus.immediate[4:0], OP_STORE};
            bTypeInstruction: enc_word = {bus.immediate[12], bus.immediate[10:5], bus.rs2, bus.rs1,
                                          bus.funct3, bus.immediate[4:1], bus.immediate[11], OP_BRANCH};
            jalInstruction:   enc_word = {bus.immediate[20], bus.immediate[10:1], bus.immediate[11],
                                          bus.immediate[19:12], bus.rd, OP_JAL};
            luiInstruction:   enc_word = {bus.immediate[31:12], bus.rd, OP_LUI};
            auipcInstruction: enc_word = {bus.immediate[31:12], bus.rd, OP_AUIPC};
            default: begin
                enc_word  = NOP_WORD;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Upper part is rounded so that the sign-extended ADDI low part lands on the exact value.
    assign li_lo    = bus.immediate[11:0];
    assign li_up    = bus.immediate[31:12] + {19'd0, bus.immediate[11]};
    assign li_small = (bus.immediate[31:11] == '0) || (bus.immediate[31:11] == '1);
    assign li_two   = !li_small && (li_lo != 12'd0);
    assign li_first = li_small ? addi_word(bus.rd, 5'd0, li_lo) : {li_up, bus.rd, OP_LUI};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_fire && bus.loadImm && li_two) state_d = LI_2;
            LI_2: if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nxt_valid   = out_valid_q && !out_fire;
        nxt_code    = code_q;
        nxt_illegal = illegal_q && !out_fire;
        capture_li  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    nxt_valid  = 1'b1;
                    capture_li = bus.loadImm && li_two;
                    if (bus.loadImm) begin
                        nxt_code    = li_first;
                        nxt_illegal = 1'b0;
                    end else begin
                        nxt_code    = enc_word;
                        nxt_illegal = !enc_legal;
                    end
                end
            end
            LI_2: begin
                if (out_fire) begin
                    nxt_valid   = 1'b1;
                    nxt_code    = addi_word(li_rd_q, li_rd_q, li_lo_q);
                    nxt_illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            code_q      <= 32'd0;
            illegal_q   <= 1'b0;
            addr_q      <= BASE_ADDR;
            li_rd_q     <= 5'd0;
            li_lo_q     <= 12'd0;
        end else begin
            out_valid_q <= nxt_valid;
            code_q      <= nxt_code;
            illegal_q   <= nxt_illegal;
            if (out_fire) begin
                addr_q <= addr_q + 32'd4;
            end
            if (capture_li) begin
                li_rd_q <= bus.rd;
                li_lo_q <= li_lo;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed vectors for the instruction encoder; expected beats go into a scoreboard queue
// and an independent monitor compares every output transfer against it.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_encoder_if bus();

    instruction_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] addr;
        logic        ill;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] exp_addr;
    int          tests = 0;
    int          fails = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_beat(input logic [31:0] code, input logic ill);
        beat_t b;
        b.code = code;
        b.addr = exp_addr;
        b.ill  = ill;
        exp_q.push_back(b);
        exp_addr += 32'd4;
    endtask

    task automatic send(input opcode_t op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic [31:0] imm, input logic li, input logic chk_rdy);
        bit got = 0;
        bus.inValid   = 1'b1;
        bus.opcode    = op;
        bus.funct7    = f7;
        bus.funct3    = f3;
        bus.rs1       = s1;
        bus.rs2       = s2;
        bus.rd        = d;
        bus.immediate = imm;
        bus.loadImm   = li;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (chk_rdy && i == 0) check32("inready_b2b", {31'd0, bus.inReady}, 32'd1);
            if (bus.inReady) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: inReady stayed %b, required 1", bus.inReady);
        end
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        bus.loadImm = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got code %h @%h, required no output",
                             bus.instructionCode, bus.instructionAddr);
                end else begin
                    b = exp_q.pop_front();
                    check32("code", bus.instructionCode, b.code);
                    check32("addr", bus.instructionAddr, b.addr);
                    check32("illegal", {31'd0, bus.illegal}, {31'd0, b.ill});
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b1;
        bus.inValid   = 1'b0;
        bus.opcode    = rTypeInstruction;
        bus.funct7    = 7'd0;
        bus.funct3    = 3'd0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.rd        = 5'd0;
        bus.immediate = 32'd0;
        bus.loadImm   = 1'b0;
        bus.outReady  = 1'b1;
        exp_addr      = 32'd0;
        #2 rst_n = 1'b0;
        #18;
        check32("rst_outvalid", {31'd0, bus.outValid}, 32'd0);
        check32("rst_code", bus.instructionCode, 32'd0);
        check32("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check32("rst_addr", bus.instructionAddr, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check32("rst_inready", {31'd0, bus.inReady}, 32'd1);
        @(posedge clk);
        #1;

        // ADD x3,x1,x2
        expect_beat(32'h002081b3, 1'b0);
        send(rTypeInstruction, 7'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0);
        // BEQ x1,x2,-20 then JAL x1,32 back to back
        expect_beat(32'hFE2086E3, 1'b0);
        send(bTypeInstruction, 7'd0, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFEC, 1'b0, 1'b1);
        expect_beat(32'h020000EF, 1'b0);
        send(jalInstruction, 7'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd32, 1'b0, 1'b1);

        // LI x5,0x12345678 (two beats, input blocked during the second)
        expect_beat(32'h123452B7, 1'b0);
        expect_beat(32'h67828293, 1'b0);
        send(rTypeInstruction, 7'd0, 3'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5678, 1'b1, 1'b0);
        @(negedge clk);
        check32("inready_li2", {31'd0, bus.inReady}, 32'd0);
        @(posedge clk);
        #1;

        expect_beat(32'h123462B7, 1'b0);
        expect_beat(32'h80028293, 1'b0);
        send(rTypeInstruction, 7'd0, 3'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5800, 1'b1, 1'b0);
        expect_beat(32'hFFB00293, 1'b0);
        send(rTypeInstruction, 7'd0, 3'd0, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFB, 1'b1, 1'b0);
        expect_beat(32'h123452B7, 1'b0);
        send(rTypeInstruction, 7'd0, 3'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 1'b1, 1'b0);

        // SRAI x1,x2,3 ; LUI x7,0xABCDE ; LW x4,-4(x3)
        expect_beat(32'h40315093, 1'b0);
        send(iTypeInstruction, 7'h20, 3'd5, 5'd2, 5'd0, 5'd1, 32'd3, 1'b0, 1'b0);
        expect_beat(32'hABCDE3B7, 1'b0);
        send(luiInstruction, 7'd0, 3'd0, 5'd0, 5'd0, 5'd7, 32'hABCD_E000, 1'b0, 1'b0);
        expect_beat(32'hFFC1A203, 1'b0);
        send(loadInstruction, 7'd0, 3'd2, 5'd3, 5'd0, 5'd4, 32'hFFFF_FFFC, 1'b0, 1'b0);
        drain();

        // SW x2,16(x1) stalled three cycles
        bus.outReady = 1'b0;
        expect_beat(32'h0020A823, 1'b0);
        send(sTypeInstruction, 7'd0, 3'd2, 5'd1, 5'd2, 5'd0, 32'd16, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("stall_code", bus.instructionCode, 32'h0020A823);
            check32("stall_valid", {31'd0, bus.outValid}, 32'd1);
            check32("stall_inready", {31'd0, bus.inReady}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.outReady = 1'b1;
        drain();
        check32("stall_addr_once", bus.instructionAddr, exp_addr);

        // Opcode value outside the enum
        expect_beat(32'h0000_0013, 1'b1);
        send(opcode_t'(4'd12), 7'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0);
        drain();

        // Reset while the ADDI of an LI is pending
        bus.outReady = 1'b0;
        send(rTypeInstruction, 7'd0, 3'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5678, 1'b1, 1'b0);
        @(negedge clk);
        check32("li2_hold_code", bus.instructionCode, 32'h123452B7);
        check32("li2_inready", {31'd0, bus.inReady}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check32("midli_outvalid", {31'd0, bus.outValid}, 32'd0);
        check32("midli_addr", bus.instructionAddr, 32'd0);
        exp_addr = 32'd0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.outReady = 1'b1;
        repeat (4) @(negedge clk);
        check32("midli_no_addi", {31'd0, bus.outValid}, 32'd0);
        @(posedge clk);
        #1;
        expect_beat(32'h002081b3, 1'b0);
        send(rTypeInstruction, 7'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
